// File: rtl/caliptra_apb_arbiter.sv
// -----------------------------------------------------------------------------
// caliptra_apb_arbiter
//
// Two-master, one-slave APB arbiter on core_clk. Shares the Caliptra wrapper
// APB slave port between the host AXI-to-APB bridge (m0) and an FPGA-side
// register sequencer (m1). Grants are round-robin and held for one complete
// APB transfer; every transfer returns to IDLE before the next grant. The slave
// side is driven from registered copies of the winning master's request.
//
// Ports
//   core_clk, core_rst          clock, synchronous active-high reset
//   mN_psel/penable/pwrite      master N (0,1) control inputs
//   mN_paddr/pwdata/pprot/pauser master N request fields
//   mN_prdata/pready/pslverr    master N response (prdata/pslverr zero unless pready)
//   s_psel/penable/pwrite       slave control outputs
//   s_paddr/pwdata/pprot/pauser slave request fields (registered)
//   s_prdata/pready/pslverr     slave response inputs
//
// Configuration
//   CALIPTRA_APB_ARB_TIMEOUT_EN  when defined, an ACCESS phase lasting
//                                TIMEOUT_CYC cycles without s_pready is
//                                terminated with pslverr=1 and
//                                prdata=32'hDEAD_0A9B. When undefined, ACCESS
//                                waits on s_pready indefinitely.
// -----------------------------------------------------------------------------
module caliptra_apb_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned USER_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic              core_clk,
   input  logic              core_rst,
   // master 0
   input  logic              m0_psel,
   input  logic              m0_penable,
   input  logic              m0_pwrite,
   input  logic [ADDR_W-1:0] m0_paddr,
   input  logic [DATA_W-1:0] m0_pwdata,
   input  logic [2:0]        m0_pprot,
   input  logic [USER_W-1:0] m0_pauser,
   output logic [DATA_W-1:0] m0_prdata,
   output logic              m0_pready,
   output logic              m0_pslverr,
   // master 1
   input  logic              m1_psel,
   input  logic              m1_penable,
   input  logic              m1_pwrite,
   input  logic [ADDR_W-1:0] m1_paddr,
   input  logic [DATA_W-1:0] m1_pwdata,
   input  logic [2:0]        m1_pprot,
   input  logic [USER_W-1:0] m1_pauser,
   output logic [DATA_W-1:0] m1_prdata,
   output logic              m1_pready,
   output logic              m1_pslverr,
   // slave
   output logic              s_psel,
   output logic              s_penable,
   output logic              s_pwrite,
   output logic [ADDR_W-1:0] s_paddr,
   output logic [DATA_W-1:0] s_pwdata,
   output logic [2:0]        s_pprot,
   output logic [USER_W-1:0] s_pauser,
   input  logic [DATA_W-1:0] s_prdata,
   input  logic              s_pready,
   input  logic              s_pslverr
);

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StResp
   } state_e;

   state_e            state_q, state_d;
   // Last winner; doubles as the owner of the transfer in flight.
   logic              rr_last_q, rr_last_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic [2:0]        pprot_q, pprot_d;
   logic [USER_W-1:0] pauser_q, pauser_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              any_req;
   logic              winner;

   assign any_req = m0_psel | m1_psel;
   // Tie goes to whoever did not win last; otherwise the sole requester.
   assign winner  = (m0_psel & m1_psel) ? ~rr_last_q : m1_psel;

   // Master penable carries no extra information here: requests are taken from psel in IDLE.
   logic unused_master_penable;
   assign unused_master_penable = m0_penable ^ m1_penable;

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
   localparam logic [DATA_W-1:0] TimeoutRdata = DATA_W'(32'hDEAD_0A9B);

   logic [15:0] cnt_q, cnt_d;
   logic        timeout_hit;

   // Hit on the TIMEOUT_CYC-th ACCESS cycle (counter starts at 0 on entry).
   assign timeout_hit = (32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYC);
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pprot_d   = pprot_q;
      pauser_d  = pauser_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               rr_last_d = winner;
               pwrite_d  = winner ? m1_pwrite : m0_pwrite;
               paddr_d   = winner ? m1_paddr  : m0_paddr;
               pwdata_d  = winner ? m1_pwdata : m0_pwdata;
               pprot_d   = winner ? m1_pprot  : m0_pprot;
               pauser_d  = winner ? m1_pauser : m0_pauser;
               state_d   = StSetup;
            end
         end
         StSetup: begin
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = StAccess;
         end
         StAccess: begin
            if (s_pready) begin
               rdata_d = pwrite_q ? '0 : s_prdata;
               err_d   = s_pslverr;
               state_d = StResp;
            end
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               rdata_d = TimeoutRdata;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q   <= StIdle;
         rr_last_q <= 1'b1;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pprot_q   <= '0;
         pauser_q  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pprot_q   <= pprot_d;
         pauser_q  <= pauser_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
`endif
      end
   end

   // Slave side: control decoded from the state register, fields from the latched request.
   assign s_psel    = (state_q == StSetup) || (state_q == StAccess);
   assign s_penable = (state_q == StAccess);
   assign s_pwrite  = pwrite_q;
   assign s_paddr   = paddr_q;
   assign s_pwdata  = pwdata_q;
   assign s_pprot   = pprot_q;
   assign s_pauser  = pauser_q;

   // Master side: only the owner sees the RESP pulse; data/err are gated to zero otherwise.
   assign m0_pready  = (state_q == StResp) && !rr_last_q;
   assign m1_pready  = (state_q == StResp) &&  rr_last_q;
   assign m0_prdata  = m0_pready ? rdata_q : '0;
   assign m1_prdata  = m1_pready ? rdata_q : '0;
   assign m0_pslverr = m0_pready & err_q;
   assign m1_pslverr = m1_pready & err_q;

endmodule

// File: tb/tb_caliptra_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_caliptra_apb_arbiter
//
// Directed bench for caliptra_apb_arbiter. Cycles are numbered from the cycle
// in which a request is presented (cycle 0). All driving and sampling happens
// on the falling clock edge: outputs are checked first, then inputs for the
// same cycle are applied. A small slave model raises s_pready after wait_cfg
// ACCESS cycles. Build with CALIPTRA_APB_ARB_TIMEOUT_EN to add the timeout case.
// -----------------------------------------------------------------------------
module tb_caliptra_apb_arbiter;

   logic        core_clk = 1'b0;
   logic        core_rst = 1'b1;

   logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
   logic [31:0] m0_paddr = '0, m0_pwdata = '0, m0_pauser = '0;
   logic [2:0]  m0_pprot = '0;
   logic [31:0] m0_prdata;
   logic        m0_pready, m0_pslverr;

   logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
   logic [31:0] m1_paddr = '0, m1_pwdata = '0, m1_pauser = '0;
   logic [2:0]  m1_pprot = '0;
   logic [31:0] m1_prdata;
   logic        m1_pready, m1_pslverr;

   logic        s_psel, s_penable, s_pwrite;
   logic [31:0] s_paddr, s_pwdata, s_pauser;
   logic [2:0]  s_pprot;
   logic [31:0] s_prdata;
   logic        s_pready, s_pslverr;

   // Slave model configuration.
   int          wait_cfg  = 0;
   int          acc_cnt   = 0;
   logic        err_cfg   = 1'b0;
   logic [31:0] rdata_cfg = '0;

   int          n_cmp = 0;
   int          n_bad = 0;

   caliptra_apb_arbiter #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .USER_W      (32),
      .TIMEOUT_CYC (8)
   ) dut (
      .core_clk   (core_clk),
      .core_rst   (core_rst),
      .m0_psel    (m0_psel),
      .m0_penable (m0_penable),
      .m0_pwrite  (m0_pwrite),
      .m0_paddr   (m0_paddr),
      .m0_pwdata  (m0_pwdata),
      .m0_pprot   (m0_pprot),
      .m0_pauser  (m0_pauser),
      .m0_prdata  (m0_prdata),
      .m0_pready  (m0_pready),
      .m0_pslverr (m0_pslverr),
      .m1_psel    (m1_psel),
      .m1_penable (m1_penable),
      .m1_pwrite  (m1_pwrite),
      .m1_paddr   (m1_paddr),
      .m1_pwdata  (m1_pwdata),
      .m1_pprot   (m1_pprot),
      .m1_pauser  (m1_pauser),
      .m1_prdata  (m1_prdata),
      .m1_pready  (m1_pready),
      .m1_pslverr (m1_pslverr),
      .s_psel     (s_psel),
      .s_penable  (s_penable),
      .s_pwrite   (s_pwrite),
      .s_paddr    (s_paddr),
      .s_pwdata   (s_pwdata),
      .s_pprot    (s_pprot),
      .s_pauser   (s_pauser),
      .s_prdata   (s_prdata),
      .s_pready   (s_pready),
      .s_pslverr  (s_pslverr)
   );

   always #5 core_clk = ~core_clk;

   // Slave: counts ACCESS cycles, readies on the (wait_cfg+1)-th one.
   always @(posedge core_clk) acc_cnt <= (s_psel && s_penable) ? acc_cnt + 1 : 0;
   assign s_pready  = s_psel && s_penable && (acc_cnt == wait_cfg);
   assign s_prdata  = rdata_cfg;
   assign s_pslverr = err_cfg;

   task automatic nc();
      @(negedge core_clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      nc();
      core_rst = 1'b1;
      nc();
      core_rst = 1'b0;
   endtask

   initial begin
      // ---------------- reset state ----------------
      nc();
      nc();
      check("rst_s_psel",    32'(s_psel),    32'd0);
      check("rst_s_penable", 32'(s_penable), 32'd0);
      check("rst_s_paddr",   s_paddr,        32'd0);
      check("rst_m0_pready", 32'(m0_pready), 32'd0);
      check("rst_m1_pready", 32'(m1_pready), 32'd0);
      core_rst = 1'b0;

      // ---------------- 1: m0 read, zero wait ----------------
      nc();                                   // c0
      check("t1_c0_s_psel", 32'(s_psel), 32'd0);
      m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3003_0000;
      m0_pprot = 3'b010; m0_pauser = 32'hABCD_0001;
      rdata_cfg = 32'h1234_5678; wait_cfg = 0;
      nc();                                   // c1
      m0_penable = 1'b1;
      check("t1_c1_s_psel",    32'(s_psel),    32'd1);
      check("t1_c1_s_penable", 32'(s_penable), 32'd0);
      check("t1_c1_s_paddr",   s_paddr,        32'h3003_0000);
      check("t1_c1_s_pprot",   32'(s_pprot),   32'd2);
      check("t1_c1_s_pauser",  s_pauser,       32'hABCD_0001);
      nc();                                   // c2
      check("t1_c2_s_penable", 32'(s_penable), 32'd1);
      check("t1_c2_m0_pready", 32'(m0_pready), 32'd0);
      check("t1_c2_m0_prdata", m0_prdata,      32'd0);
      nc();                                   // c3
      check("t1_c3_m0_pready",  32'(m0_pready),  32'd1);
      check("t1_c3_m0_prdata",  m0_prdata,       32'h1234_5678);
      check("t1_c3_m0_pslverr", 32'(m0_pslverr), 32'd0);
      check("t1_c3_m1_pready",  32'(m1_pready),  32'd0);
      check("t1_c3_s_psel",     32'(s_psel),     32'd0);
      m0_psel = 1'b0; m0_penable = 1'b0;
      nc();                                   // c4
      check("t1_c4_m0_pready", 32'(m0_pready), 32'd0);
      check("t1_c4_m0_prdata", m0_prdata,      32'd0);

      // ---------------- 2: contention after reset ----------------
      do_reset();
      nc();                                   // c0
      m0_psel = 1'b1; m0_paddr = 32'h3003_0010;
      m1_psel = 1'b1; m1_paddr = 32'h3003_0020; m1_pwrite = 1'b0;
      rdata_cfg = 32'h0000_0042;
      for (int c = 1; c <= 15; c++) begin
         nc();
         if (c % 4 == 1) begin
            check("t2_owner_paddr", s_paddr,
                  ((c / 4) % 2 == 0) ? 32'h3003_0010 : 32'h3003_0020);
         end
         if (c % 4 == 3) begin
            check("t2_m0_pready", 32'(m0_pready), ((c / 4) % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_m1_pready", 32'(m1_pready), ((c / 4) % 2 == 0) ? 32'd0 : 32'd1);
         end
      end
      m0_psel = 1'b0; m1_psel = 1'b0;

      // ---------------- 3: m1 write, 3 wait states ----------------
      nc();                                   // c0
      m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h3003_0100;
      m1_pwdata = 32'hA5A5_A5A5; wait_cfg = 3; rdata_cfg = 32'hFFFF_0000;
      for (int c = 1; c <= 5; c++) begin
         nc();
         if (c == 2) m1_pwdata = 32'h0000_0000; // mid-transfer change must be ignored
         check("t3_s_pwdata",   s_pwdata,       32'hA5A5_A5A5);
         check("t3_s_pwrite",   32'(s_pwrite),  32'd1);
         check("t3_m1_pready",  32'(m1_pready), 32'd0);
      end
      nc();                                   // c6
      check("t3_c6_m1_pready", 32'(m1_pready), 32'd1);
      check("t3_c6_m1_prdata", m1_prdata,      32'd0);
      check("t3_c6_m0_pready", 32'(m0_pready), 32'd0);
      m1_psel = 1'b0; m1_pwrite = 1'b0; wait_cfg = 0;

      // ---------------- 4: slave error, then clean grant ----------------
      nc();                                   // c0
      m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3003_0040;
      err_cfg = 1'b1; rdata_cfg = 32'hCAFE_F00D;
      nc(); nc();                             // c2
      check("t4_c2_m0_pslverr", 32'(m0_pslverr), 32'd0);
      nc();                                   // c3
      check("t4_c3_m0_pready",  32'(m0_pready),  32'd1);
      check("t4_c3_m0_pslverr", 32'(m0_pslverr), 32'd1);
      m0_psel = 1'b0; err_cfg = 1'b0;
      nc();                                   // c4 == next c0
      check("t4_c4_m0_pslverr", 32'(m0_pslverr), 32'd0);
      check("t4_c4_m0_pready",  32'(m0_pready),  32'd0);
      m0_psel = 1'b1; rdata_cfg = 32'h0BAD_CAFE;
      nc(); nc(); nc();                       // c3
      check("t4b_m0_pready",  32'(m0_pready),  32'd1);
      check("t4b_m0_pslverr", 32'(m0_pslverr), 32'd0);
      check("t4b_m0_prdata",  m0_prdata,       32'h0BAD_CAFE);
      m0_psel = 1'b0;

      // ---------------- 5: reset during ACCESS ----------------
      nc();                                   // c0
      m0_psel = 1'b1; m0_paddr = 32'h3003_0080; wait_cfg = 1000;
      nc(); nc(); nc();                       // c3
      check("t5_c3_s_penable", 32'(s_penable), 32'd1);
      core_rst = 1'b1; m0_psel = 1'b0;
      nc();                                   // c4: reset applied
      check("t5_rst_s_psel",    32'(s_psel),    32'd0);
      check("t5_rst_s_penable", 32'(s_penable), 32'd0);
      check("t5_rst_s_paddr",   s_paddr,        32'd0);
      check("t5_rst_m0_pready", 32'(m0_pready), 32'd0);
      check("t5_rst_m1_pready", 32'(m1_pready), 32'd0);
      core_rst = 1'b0; wait_cfg = 0; rdata_cfg = 32'h5555_0000;
      m0_psel = 1'b1; m0_paddr = 32'h3003_00C0;
      m1_psel = 1'b1; m1_paddr = 32'h3003_00D0;
      nc();                                   // c1
      check("t5_first_owner", s_paddr, 32'h3003_00C0);
      nc(); nc();                             // c3
      check("t5_m0_pready", 32'(m0_pready), 32'd1);
      check("t5_m1_idle",   32'(m1_pready), 32'd0);
      m0_psel = 1'b0;
      nc(); nc();                             // c5
      check("t5_second_owner", s_paddr, 32'h3003_00D0);
      nc(); nc();                             // c7
      check("t5_m1_pready", 32'(m1_pready), 32'd1);
      m1_psel = 1'b0;

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
      // ---------------- 6: timeout ----------------
      nc();                                   // c0
      m0_psel = 1'b1; m0_paddr = 32'h3003_0200;
      m1_psel = 1'b1; m1_paddr = 32'h3003_0300;
      wait_cfg = 1000;
      for (int c = 1; c <= 9; c++) begin
         nc();
         check("t6_m0_wait", 32'(m0_pready), 32'd0);
      end
      nc();                                   // c10
      check("t6_m0_pready",  32'(m0_pready),  32'd1);
      check("t6_m0_pslverr", 32'(m0_pslverr), 32'd1);
      check("t6_m0_prdata",  m0_prdata,       32'hDEAD_0A9B);
      check("t6_s_psel",     32'(s_psel),     32'd0);
      m0_psel = 1'b0; wait_cfg = 0; rdata_cfg = 32'h7777_1111;
      nc(); nc();                             // c12
      check("t6_m1_owner", s_paddr, 32'h3003_0300);
      nc(); nc();                             // c14
      check("t6_m1_pready",  32'(m1_pready),  32'd1);
      check("t6_m1_pslverr", 32'(m1_pslverr), 32'd0);
      check("t6_m1_prdata",  m1_prdata,       32'h7777_1111);
      m1_psel = 1'b0;
`endif

      nc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
